// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared state encoding, default geometry and clamp helper for the ball engine
package ball_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_MISS  = 2'b11
    } state_t;

    localparam int DEF_H_RES       = 640;
    localparam int DEF_V_RES       = 480;
    localparam int DEF_BALL_SIZE   = 8;
    localparam int DEF_PADDLE_W    = 64;
    localparam int DEF_PADDLE_Y    = 440;
    localparam int DEF_MISS_FRAMES = 60;
    localparam int DEF_XW          = 10;
    localparam int DEF_YW          = 9;

    // Saturate v into [lo, hi]; used for parking the ball above an off-screen paddle.
    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - two-flop button synchroniser with rising-edge pulse output
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_edge
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Bring the raw button into the clk domain and keep one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    // Pulse for exactly one cycle when the synchronised level rises.
    always_comb begin
        btn_edge = sync2 & ~sync2_d;
    end

endmodule

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - per-frame ball position, rebounds, paddle hits, serve/pause and miss handling
module ball_engine
    import ball_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int PADDLE_W    = DEF_PADDLE_W,
    parameter int PADDLE_Y    = DEF_PADDLE_Y,
    parameter int MISS_FRAMES = DEF_MISS_FRAMES,
    parameter int XW          = DEF_XW,
    parameter int YW          = DEF_YW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          btn,
    input  logic [1:0]    speed_sel,
    input  logic [XW-1:0] paddle_x,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          dir_x,
    output logic          dir_y,
    output logic [1:0]    state,
    output logic          hit,
    output logic          miss,
    output logic [7:0]    score
);

    localparam int MW = $clog2(MISS_FRAMES + 1);

    // Unsigned geometry in coordinate widths.
    localparam logic [XW-1:0] X_RST  = XW'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [XW-1:0] X_MAX  = XW'(H_RES - BALL_SIZE);
    localparam logic [YW-1:0] Y_PARK = YW'(PADDLE_Y - BALL_SIZE);
    localparam logic [YW-1:0] Y_MAX  = YW'(V_RES - BALL_SIZE);
    localparam logic [XW:0]   BS_X   = (XW + 1)'(BALL_SIZE);
    localparam logic [XW:0]   PW_X   = (XW + 1)'(PADDLE_W);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_FRAMES - 1);

    // Signed thresholds one bit wider, so a step past zero reads as negative.
    localparam logic signed [XW:0] X_ZERO_S = '0;
    localparam logic signed [XW:0] X_MAX_S  = (XW + 1)'(H_RES - BALL_SIZE);
    localparam logic signed [YW:0] Y_ZERO_S = '0;
    localparam logic signed [YW:0] Y_PARK_S = (YW + 1)'(PADDLE_Y - BALL_SIZE);
    localparam logic signed [YW:0] Y_MAX_S  = (YW + 1)'(V_RES - BALL_SIZE);

    state_t          st;
    logic [MW-1:0]   miss_cnt;
    logic            btn_edge;

    logic [XW:0]          step_x;
    logic [YW:0]          step_y;
    logic signed [XW:0]   nx;
    logic signed [YW:0]   ny;
    logic [XW-1:0]        x_new;
    logic [YW-1:0]        y_new;
    logic                 dx_new;
    logic                 dy_new;
    logic                 overlap;
    logic                 do_hit;
    logic                 do_miss;
    logic [XW-1:0]        park_x;
    logic [7:0]           score_inc;

    btn_edge_sync u_btn (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .btn_edge (btn_edge)
    );

    // Candidate next position for one RUN frame; both axes resolve together so corners flip both directions.
    always_comb begin
        step_x  = (XW + 1)'(speed_sel) + (XW + 1)'(1);
        step_y  = (YW + 1)'(speed_sel) + (YW + 1)'(1);
        nx      = dir_x ? signed'({1'b0, x} + step_x) : signed'({1'b0, x} - step_x);
        ny      = dir_y ? signed'({1'b0, y} + step_y) : signed'({1'b0, y} - step_y);
        x_new   = x;
        y_new   = y;
        dx_new  = dir_x;
        dy_new  = dir_y;
        do_hit  = 1'b0;
        do_miss = 1'b0;

        if (nx <= X_ZERO_S) begin
            x_new  = '0;
            dx_new = 1'b1;
        end else if (nx >= X_MAX_S) begin
            x_new  = X_MAX;
            dx_new = 1'b0;
        end else begin
            x_new = nx[XW-1:0];
        end

        // Paddle overlap is judged against the already-updated x.
        overlap = (({1'b0, x_new} + BS_X) > {1'b0, paddle_x}) &&
                  ({1'b0, x_new} < ({1'b0, paddle_x} + PW_X));

        if (ny <= Y_ZERO_S) begin
            y_new  = '0;
            dy_new = 1'b1;
        end else if (dir_y && (ny >= Y_PARK_S) && (y <= Y_PARK) && overlap) begin
            y_new  = Y_PARK;
            dy_new = 1'b0;
            do_hit = 1'b1;
        end else if (ny >= Y_MAX_S) begin
            y_new   = Y_MAX;
            do_miss = 1'b1;
        end else begin
            y_new = ny[YW-1:0];
        end

        park_x    = XW'(clamp(int'(paddle_x) + PADDLE_W / 2 - BALL_SIZE / 2, 0, H_RES - BALL_SIZE));
        score_inc = (score == 8'hFF) ? score : score + 8'd1;
    end

    // Game state machine; motion only on frame_tick, button edges win over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            x        <= X_RST;
            y        <= Y_PARK;
            dir_x    <= 1'b1;
            dir_y    <= 1'b0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            score    <= 8'd0;
            miss_cnt <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (btn_edge) begin
                        st    <= ST_RUN;
                        dir_x <= 1'b1;
                        dir_y <= 1'b0;
                        score <= 8'd0;
                    end else if (frame_tick) begin
                        x <= park_x;
                        y <= Y_PARK;
                    end
                end
                ST_RUN: begin
                    if (btn_edge) begin
                        st <= ST_PAUSE;
                    end else if (frame_tick) begin
                        x     <= x_new;
                        y     <= y_new;
                        dir_x <= dx_new;
                        dir_y <= dy_new;
                        if (do_hit) begin
                            hit   <= 1'b1;
                            score <= score_inc;
                        end
                        if (do_miss) begin
                            miss     <= 1'b1;
                            st       <= ST_MISS;
                            miss_cnt <= '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (btn_edge)
                        st <= ST_RUN;
                end
                ST_MISS: begin
                    if (frame_tick) begin
                        miss_cnt <= miss_cnt + MW'(1);
                        if (miss_cnt == MISS_LAST)
                            st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // State is exported directly from the register.
    always_comb begin
        state = st;
    end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Parametrised successor to the fixed-size `bounce` ball generator.
- Computes the per-frame position of one ball for the game display. It handles wall rebounds, paddle collisions, a serve/pause button and miss detection.
- Sits between the frame-timing logic (which supplies `frame_tick`) and the pixel renderer (which consumes `x` and `y`).
- All state updates occur only on `frame_tick`, except the button edge detect, which runs every `clk` cycle.

Parameters:
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- BALL_SIZE, 8, ball edge length in pixels (square ball).
- PADDLE_W, 64, paddle width in pixels.
- PADDLE_Y, 440, top row of the paddle.
- MISS_FRAMES, 60, frames spent in MISS before returning to IDLE.
- XW, 10, x coordinate width; must satisfy 2^XW > H_RES.
- YW, 9, y coordinate width; must satisfy 2^YW > V_RES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per frame.
- btn  in  1  raw serve/pause button.
- speed_sel  in  2  step per frame = speed_sel+1 pixels, on both axes.
- paddle_x  in  XW  paddle left edge.
- x  out  XW  ball left edge.
- y  out  YW  ball top edge.
- dir_x  out  1  1 = moving right.
- dir_y  out  1  1 = moving down.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 MISS.
- hit  out  1  one-cycle pulse on paddle contact.
- miss  out  1  one-cycle pulse on entering MISS.
- score  out  8  paddle hits since last serve, saturating at 255.

Behaviour:
- Reset is synchronous, active-high, and overrides everything including mid-flight motion. Reset values:
  - state = IDLE
  - x = H_RES/2 - BALL_SIZE/2 (316)
  - y = PADDLE_Y - BALL_SIZE (432)
  - dir_x = 1, dir_y = 0
  - hit = 0, miss = 0, score = 0
  - miss counter = 0, button synchroniser flops = 0
- Button handling: `btn` goes through a 2-flop synchroniser, then a rising-edge detector. The resulting `btn_edge` is a single-cycle pulse; latency is 2 clk from the input edge to the pulse. Debouncing is out of scope.
- `speed_sel` is sampled at each `frame_tick`.
- IDLE:
  - On each `frame_tick`: x = paddle_x + PADDLE_W/2 - BALL_SIZE/2, clamped to [0, H_RES-BALL_SIZE]; y = PADDLE_Y - BALL_SIZE.
  - `btn_edge` moves to RUN with dir_x = 1, dir_y = 0, score = 0.
  - If `btn_edge` and `frame_tick` coincide: the transition wins and no motion occurs that cycle.
- RUN: on each `frame_tick`, compute next positions in XW+1 / YW+1 bit signed arithmetic, with s = speed_sel+1.
  - X axis: nx = x ± s.
    - If nx <= 0: x = 0, dir_x = 1.
    - Else if nx >= H_RES-BALL_SIZE: x = H_RES-BALL_SIZE, dir_x = 0.
    - Else: x = nx.
  - Y axis: ny = y ± s.
    - If ny <= 0: y = 0, dir_y = 1.
    - If moving down, ny + BALL_SIZE >= PADDLE_Y, the old y + BALL_SIZE <= PADDLE_Y, and x-overlap holds: y = PADDLE_Y - BALL_SIZE, dir_y = 0, `hit` pulses, score increments (saturating).
    - x-overlap is defined as: x + BALL_SIZE > paddle_x and x < paddle_x + PADDLE_W, using the updated x.
    - Else if ny >= V_RES - BALL_SIZE: y = V_RES - BALL_SIZE, `miss` pulses, state = MISS, miss counter = 0.
  - Both axes are evaluated in the same tick, so a corner flips both directions.
  - `btn_edge` in RUN moves to PAUSE. If it coincides with `frame_tick`, the pause wins and there is no motion.
- PAUSE: position and directions are frozen; `btn_edge` returns to RUN.
- MISS:
  - Position frozen; `btn` ignored.
  - The counter increments on `frame_tick`.
  - On the tick where the counter reaches MISS_FRAMES-1, the next state is IDLE.
  - In IDLE the ball re-parks on the following tick.
- `hit` and `miss` are registered and last exactly one clk cycle.

Decomposition:
- Package `ball_pkg` holds:
  - the state enum: IDLE, RUN, PAUSE, MISS
  - the default geometry constants
  - a function for the clamp helper
- One natural sub-module: `btn_edge_sync`, containing the 2-flop synchroniser plus rising-edge detector.
- The axis-update logic stays inline.

Test Plan:
- Reset and park: rst=1 for 2 cycles, then paddle_x=288, 1 tick -> x=316, y=432, state=00, score=0.
- Serve at slowest speed: speed_sel=0, btn pulse, 2 ticks -> state=01, then x=317, y=431 after the first tick, x=318, y=430 after the second.
- Wall bounces: speed_sel=3, serve from x=316, y=432 -> at tick 79 x=632 and dir_x=0; at tick 108 y=0 and dir_y=1; no hit or miss pulses.
- Paddle hit: after the top rebound, hold paddle_x tracking the ball -> y clamps to 432, dir_y=0, hit high for 1 cycle, score=1.
- Miss and recovery: paddle_x=0 while the ball descends at x>100 -> y=472, miss 1-cycle pulse, state=11; btn pulses ignored; after 60 ticks state=00; next tick x = paddle-centred value.
- Pause and reset mid-flight: btn during RUN -> state=10 with x and y frozen across 5 ticks; btn again -> RUN resumes from the same point; rst asserted mid-RUN -> next cycle has all reset values.
